// File: rtl/game_screen_sequencer.sv
// game_screen_sequencer: logo/ready/play/times-up/leaderboard screen sequencer with second countdown and hit scoring.
// Optional build macro SEQ_HIT_LOCKOUT_EN adds a per-player hit lockout of LOCKOUT_CYC cycles.
module game_screen_sequencer #(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned READY_SECS  = 3,
  parameter int unsigned PLAY_SECS   = 60,
  parameter int unsigned TU_SECS     = 2,
  parameter int unsigned BOARD_SECS  = 10,
  parameter int unsigned LOCKOUT_CYC = 1000000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       abort,
  input  logic       two_player_mode,
  input  logic       hit_p1,
  input  logic       hit_p2,
  output logic [2:0] screen,
  output logic       logo,
  output logic       get_ready,
  output logic       play,
  output logic       times_up,
  output logic       leaderboard,
  output logic [7:0] seconds_left,
  output logic [7:0] score_p1,
  output logic [7:0] score_p2,
  output logic [1:0] winner
);
  typedef enum logic [2:0] {
    S_LOGO  = 3'd0,
    S_READY = 3'd1,
    S_PLAY  = 3'd2,
    S_TU    = 3'd3,
    S_BOARD = 3'd4
  } state_t;

  state_t      r_state, w_next;
  logic [31:0] r_pre;
  logic [7:0]  r_secs, r_p1, r_p2, w_secs_ld, w_p1, w_p2;
  logic [4:0]  r_flags;
  logic [1:0]  r_win, w_win;
  logic        r_two, r_h1, r_h2;
  logic        w_tick, w_exp, w_chg, w_entry, w_ok1, w_ok2, w_acc1, w_acc2;

  assign w_tick  = r_pre == 32'(CLK_HZ - 1);
  assign w_exp   = w_tick && r_secs == 8'd1;
  assign w_chg   = w_next != r_state;
  assign w_entry = r_state == S_READY && w_next == S_PLAY;

  always_comb begin
    w_next = r_state;
    if (abort) w_next = S_LOGO;
    else
      case (r_state)
        S_LOGO:  w_next = start ? S_READY : S_LOGO;
        S_READY: w_next = w_exp ? S_PLAY : S_READY;
        S_PLAY:  w_next = w_exp ? S_TU : S_PLAY;
        S_TU:    w_next = w_exp ? S_BOARD : S_TU;
        S_BOARD: w_next = start ? S_READY : w_exp ? S_LOGO : S_BOARD;
        default: w_next = S_LOGO;
      endcase
  end

  assign w_secs_ld = w_next == S_READY ? 8'(READY_SECS) :
                     w_next == S_PLAY  ? 8'(PLAY_SECS)  :
                     w_next == S_TU    ? 8'(TU_SECS)    :
                     w_next == S_BOARD ? 8'(BOARD_SECS) : 8'd0;

`ifdef SEQ_HIT_LOCKOUT_EN
  logic [31:0] r_lk1, r_lk2;
  assign w_ok1 = r_lk1 == 32'd0;
  assign w_ok2 = r_lk2 == 32'd0;
  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_lk1 <= '0;
      r_lk2 <= '0;
    end else begin
      r_lk1 <= w_entry ? 32'd0 : w_acc1 ? 32'(LOCKOUT_CYC) : (r_lk1 != 32'd0) ? r_lk1 - 32'd1 : r_lk1;
      r_lk2 <= w_entry ? 32'd0 : w_acc2 ? 32'(LOCKOUT_CYC) : (r_lk2 != 32'd0) ? r_lk2 - 32'd1 : r_lk2;
    end
`else
  assign w_ok1 = 1'b1;
  assign w_ok2 = 1'b1;
`endif

  // P2 edges only count when two-player mode was latched at play entry
  assign w_acc1 = hit_p1 && !r_h1 && r_state == S_PLAY && w_ok1;
  assign w_acc2 = hit_p2 && !r_h2 && r_state == S_PLAY && r_two && w_ok2;
  assign w_p1   = (w_acc1 && r_p1 != 8'hFF) ? r_p1 + 8'd1 : r_p1;
  assign w_p2   = (w_acc2 && r_p2 != 8'hFF) ? r_p2 + 8'd1 : r_p2;
  assign w_win  = !r_two ? 2'b01 : (w_p1 > w_p2) ? 2'b01 : (w_p2 > w_p1) ? 2'b10 : 2'b11;

  always_ff @(posedge clock or negedge resetn)
    if (!resetn) begin
      r_state <= S_LOGO;
      r_flags <= 5'b00001;
      r_pre   <= '0;
      r_secs  <= '0;
      r_p1    <= '0;
      r_p2    <= '0;
      r_win   <= '0;
      r_two   <= 1'b0;
      r_h1    <= 1'b0;
      r_h2    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_flags <= 5'd1 << w_next;
      r_pre   <= (w_chg || w_tick) ? 32'd0 : r_pre + 32'd1;
      r_secs  <= w_chg ? w_secs_ld : (w_tick && r_secs != 8'd0) ? r_secs - 8'd1 : r_secs;
      r_h1    <= hit_p1;
      r_h2    <= hit_p2;
      if (w_entry) begin
        r_p1  <= '0;
        r_p2  <= '0;
        r_win <= '0;
        r_two <= two_player_mode;
      end else begin
        r_p1 <= w_p1;
        r_p2 <= w_p2;
        if (r_state == S_PLAY && w_next == S_TU) r_win <= w_win;
      end
    end

  assign screen       = r_state;
  assign {leaderboard, times_up, play, get_ready, logo} = r_flags;
  assign seconds_left = r_secs;
  assign score_p1     = r_p1;
  assign score_p2     = r_p2;
  assign winner       = r_win;
endmodule
